// File: rtl/reg_file_mp.sv
// reg_file_mp: XLEN x NREGS register file with x0 = 0, two read / two write ports, write->read bypass and busy scoreboard
// ports: clk, rst (sync, active-high)
//    ra1/ra2 -> rd1/rd2 data, busy1/busy2 reservation flags (all combinational)
//    we0/wa0/wd0 ALU writeback, we1/wa1/wd1 load writeback (port 1 wins on same-address collision)
//    rsv/rsv_addr mark a destination register busy at issue
module reg_file_mp #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int AW     = $clog2(NREGS),
   parameter bit BYPASS = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            busy1,
   output logic            busy2,
   input  logic            we0,
   input  logic [AW-1:0]   wa0,
   input  logic [XLEN-1:0] wd0,
   input  logic            we1,
   input  logic [AW-1:0]   wa1,
   input  logic [XLEN-1:0] wd1,
   input  logic            rsv,
   input  logic [AW-1:0]   rsv_addr
);
   logic [XLEN-1:0] regs [NREGS];
   logic [NREGS-1:0] busy;
   logic byp_ok;
   assign byp_ok = BYPASS && !rst;
   // port 1 assignments follow port 0 so the load wins a collision; the reserve follows both clears so set wins
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         busy <= '0;
      end else begin
         if (we0 && wa0 != '0) begin
            regs[wa0] <= wd0;
            busy[wa0] <= 1'b0;
         end
         if (we1 && wa1 != '0) begin
            regs[wa1] <= wd1;
            busy[wa1] <= 1'b0;
         end
         if (rsv && rsv_addr != '0) busy[rsv_addr] <= 1'b1;
      end
   end
   always_comb begin
      rd1 = ra1 == '0 ? '0 : byp_ok && we1 && wa1 == ra1 ? wd1 : byp_ok && we0 && wa0 == ra1 ? wd0 : regs[ra1];
      rd2 = ra2 == '0 ? '0 : byp_ok && we1 && wa1 == ra2 ? wd1 : byp_ok && we0 && wa0 == ra2 ? wd0 : regs[ra2];
      busy1 = ra1 != '0 && busy[ra1];
      busy2 = ra2 != '0 && busy[ra2];
   end
endmodule
